// File: rtl/controlador_pkg.sv
// controlador_pkg
// Shared definitions for the multichannel search sequencer: state encodings,
// error codes and the helper that tells which states are guarded by the watchdog.
// No ports (package).
package controlador_pkg;

  localparam int STATE_WIDTH = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE             = 3'd0,
    ST_INICIALIZAR      = 3'd1,
    ST_TEM_ATIVO        = 3'd2,
    ST_ATUALIZAR_BUFFER = 3'd3,
    ST_EXPANDIR         = 3'd4,
    ST_CONSTRUIR        = 3'd5,
    ST_PRONTO           = 3'd6,
    ST_ERRO             = 3'd7
  } estado_t;

  localparam logic [1:0] ERR_NENHUM  = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ITER    = 2'b10;
  localparam logic [1:0] ERR_ABORTO  = 2'b11;

  // States that wait on an external unit and can therefore hang.
  function automatic logic estado_vigiado(input estado_t s);
    logic r;
    case (s)
      ST_INICIALIZAR,
      ST_TEM_ATIVO,
      ST_EXPANDIR,
      ST_CONSTRUIR: r = 1'b1;
      default:      r = 1'b0;
    endcase
    return r;
  endfunction

  // States in which an abort request is honoured.
  function automatic logic estado_abortavel(input estado_t s);
    logic r;
    case (s)
      ST_IDLE,
      ST_PRONTO,
      ST_ERRO: r = 1'b0;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/contador_timeout.sv
// contador_timeout
// Watchdog for the search sequencer. Counts cycles spent in a guarded state and
// flags expiry on the cycle the count reaches TIMEOUT-1. TIMEOUT=0 disables it.
// Ports:
//   clk      in  clock
//   rst_n    in  async active-low reset
//   clear    in  restart counting (state change / restart)
//   enable   in  current state is guarded
//   expirado out guarded state has lasted TIMEOUT cycles (comb)
module contador_timeout #(
  parameter int TIMEOUT_W = 12,
  parameter int TIMEOUT   = 4000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expirado
);

  localparam logic [TIMEOUT_W-1:0] LIMITE =
    (TIMEOUT > 0) ? TIMEOUT_W'(TIMEOUT - 1) : {TIMEOUT_W{1'b0}};

  logic [TIMEOUT_W-1:0] contagem_r;

  // Expiry decode; forced low when the watchdog is disabled.
  always_comb begin
    expirado = 1'b0;
    if (TIMEOUT > 0) begin
      expirado = enable && (contagem_r == LIMITE);
    end else begin
      expirado = 1'b0;
    end
  end

  // Cycle counter; holds at the limit so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contagem_r <= {TIMEOUT_W{1'b0}};
    end else if (clear || !enable) begin
      contagem_r <= {TIMEOUT_W{1'b0}};
    end else if (!expirado) begin
      contagem_r <= contagem_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    end else begin
      contagem_r <= contagem_r;
    end
  end

endmodule

// File: rtl/controlador_busca_multicanal.sv
// controlador_busca_multicanal
// Search-sequencing FSM with N_CANAIS parallel expander channels:
// init -> active-check -> buffer update -> expand -> path build -> done,
// with iteration limit, per-phase watchdog, abort and error code.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   iniciar_in / abortar_in  host start (highest priority) / abort
//   tem_ativo_in, aa_pronto_in   active-node evaluator result
//   canais_validos_in        channels loaded during buffer update
//   lvv_pronto_in            per-channel expansion done pulse
//   caminho_pronto_in        path builder finished
//   lido_in                  host consumed result/error
//   aguardando_out .. erro_out   state decodes (comb)
//   expandir_out             per-channel expand request (reg)
//   cod_erro_out             00 none, 01 timeout, 10 iter limit, 11 abort (reg)
//   iteracoes_out            completed expansion rounds, saturating (reg)
//   estado_out               current state encoding
module controlador_busca_multicanal
  import controlador_pkg::*;
#(
  parameter int N_CANAIS  = 4,
  parameter int ITER_W    = 16,
  parameter int MAX_ITER  = 65535,
  parameter int TIMEOUT_W = 12,
  parameter int TIMEOUT   = 4000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iniciar_in,
  input  logic                abortar_in,
  input  logic                tem_ativo_in,
  input  logic                aa_pronto_in,
  input  logic [N_CANAIS-1:0] canais_validos_in,
  input  logic [N_CANAIS-1:0] lvv_pronto_in,
  input  logic                caminho_pronto_in,
  input  logic                lido_in,
  output logic                aguardando_out,
  output logic                iniciar_out,
  output logic                tem_ativo_out,
  output logic                atualizar_buffer_out,
  output logic [N_CANAIS-1:0] expandir_out,
  output logic                construir_caminho_out,
  output logic                caminho_pronto_out,
  output logic                erro_out,
  output logic [1:0]          cod_erro_out,
  output logic [ITER_W-1:0]   iteracoes_out,
  output logic [2:0]          estado_out
);

  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

  estado_t             estado_r, estado_s;
  logic [N_CANAIS-1:0] pend_r, pend_s;
  logic [1:0]          cod_erro_r, cod_erro_s;
  logic [ITER_W-1:0]   iter_r, iter_s;
  logic                expirado_s;
  logic                vigiado_s;
  logic                limpar_wd_s;

  assign vigiado_s   = estado_vigiado(estado_r);
  // A repeated start also restarts the watchdog even though the state is unchanged.
  assign limpar_wd_s = iniciar_in || (estado_s != estado_r);

  contador_timeout #(
    .TIMEOUT_W (TIMEOUT_W),
    .TIMEOUT   (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (limpar_wd_s),
    .enable   (vigiado_s),
    .expirado (expirado_s)
  );

  // Next state, pending mask, error code and iteration count.
  always_comb begin
    estado_s   = estado_r;
    pend_s     = pend_r;
    cod_erro_s = cod_erro_r;
    iter_s     = iter_r;
    if (iniciar_in) begin
      estado_s   = ST_INICIALIZAR;
      pend_s     = {N_CANAIS{1'b0}};
      cod_erro_s = ERR_NENHUM;
      iter_s     = {ITER_W{1'b0}};
    end else if (abortar_in && estado_abortavel(estado_r)) begin
      estado_s   = ST_ERRO;
      cod_erro_s = ERR_ABORTO;
    end else if (expirado_s) begin
      estado_s   = ST_ERRO;
      cod_erro_s = ERR_TIMEOUT;
    end else begin
      case (estado_r)
        ST_IDLE: begin
          estado_s = ST_IDLE;
        end
        ST_INICIALIZAR: begin
          if (tem_ativo_in && aa_pronto_in) begin
            estado_s = ST_TEM_ATIVO;
          end else begin
            estado_s = ST_INICIALIZAR;
          end
        end
        ST_TEM_ATIVO: begin
          if (!aa_pronto_in) begin
            estado_s = ST_TEM_ATIVO;
          end else if (!tem_ativo_in) begin
            estado_s = ST_CONSTRUIR;
          end else if (iter_r == ITER_MAX) begin
            estado_s   = ST_ERRO;
            cod_erro_s = ERR_ITER;
          end else begin
            estado_s = ST_ATUALIZAR_BUFFER;
            // Guard keeps the counter saturating even if the limit logic changes.
            if (iter_r < ITER_MAX) begin
              iter_s = iter_r + {{(ITER_W-1){1'b0}}, 1'b1};
            end else begin
              iter_s = iter_r;
            end
          end
        end
        ST_ATUALIZAR_BUFFER: begin
          pend_s = canais_validos_in;
          if (canais_validos_in == {N_CANAIS{1'b0}}) begin
            estado_s = ST_TEM_ATIVO;
          end else begin
            estado_s = ST_EXPANDIR;
          end
        end
        ST_EXPANDIR: begin
          // Done pulses on channels not pending simply have no effect.
          pend_s = pend_r & ~lvv_pronto_in;
          if (pend_s == {N_CANAIS{1'b0}}) begin
            estado_s = ST_TEM_ATIVO;
          end else begin
            estado_s = ST_EXPANDIR;
          end
        end
        ST_CONSTRUIR: begin
          if (caminho_pronto_in) begin
            estado_s = ST_PRONTO;
          end else begin
            estado_s = ST_CONSTRUIR;
          end
        end
        ST_PRONTO, ST_ERRO: begin
          if (lido_in) begin
            estado_s = ST_IDLE;
          end else begin
            estado_s = estado_r;
          end
        end
        default: begin
          estado_s = ST_IDLE;
        end
      endcase
    end
    // Requests only live while expanding; leaving EXPANDIR drops them all.
    if (estado_s != ST_EXPANDIR) begin
      pend_s = {N_CANAIS{1'b0}};
    end else begin
      pend_s = pend_s;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_r   <= ST_IDLE;
      pend_r     <= {N_CANAIS{1'b0}};
      cod_erro_r <= ERR_NENHUM;
      iter_r     <= {ITER_W{1'b0}};
    end else begin
      estado_r   <= estado_s;
      pend_r     <= pend_s;
      cod_erro_r <= cod_erro_s;
      iter_r     <= iter_s;
    end
  end

  // The pending mask is the registered expand request.
  assign expandir_out  = pend_r;
  assign cod_erro_out  = cod_erro_r;
  assign iteracoes_out = iter_r;
  assign estado_out    = estado_r;

  assign aguardando_out        = (estado_r == ST_IDLE);
  assign iniciar_out           = (estado_r == ST_INICIALIZAR);
  assign tem_ativo_out         = (estado_r == ST_TEM_ATIVO);
  assign atualizar_buffer_out  = (estado_r == ST_ATUALIZAR_BUFFER);
  assign construir_caminho_out = (estado_r == ST_CONSTRUIR);
  assign caminho_pronto_out    = (estado_r == ST_PRONTO);
  assign erro_out              = (estado_r == ST_ERRO);

endmodule

// File: tb/tb_controlador_busca_multicanal.sv
// tb_controlador_busca_multicanal
// Two instances share one stimulus stream: A (MAX_ITER=6, TIMEOUT=16) and
// B (MAX_ITER=2, watchdog off). A behavioural model per instance is checked
// every cycle; directed sequences add literal expectations.
module tb_controlador_busca_multicanal;

  localparam int MI [2] = '{6, 2};
  localparam int TO [2] = '{16, 0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ini = 1'b0, ab = 1'b0, ta = 1'b0, ap = 1'b0, cp = 1'b0, li = 1'b0;
  logic [3:0] cv = 4'd0, lp = 4'd0;

  logic [1:0][6:0]  dec_w;
  logic [1:0][3:0]  expandir_w;
  logic [1:0][1:0]  cod_w;
  logic [1:0][15:0] iter_w;
  logic [1:0][2:0]  estado_w;

  int checks = 0;
  int fails  = 0;
  bit cmp_en = 1'b0;

  int m_st [2];
  int m_iter [2];
  int m_cod [2];
  int m_pend [2];
  int m_wd [2];

  always #5 clk = ~clk;

  controlador_busca_multicanal #(
    .N_CANAIS(4), .ITER_W(16), .MAX_ITER(6), .TIMEOUT_W(12), .TIMEOUT(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .iniciar_in(ini), .abortar_in(ab),
    .tem_ativo_in(ta), .aa_pronto_in(ap), .canais_validos_in(cv),
    .lvv_pronto_in(lp), .caminho_pronto_in(cp), .lido_in(li),
    .aguardando_out(dec_w[0][0]), .iniciar_out(dec_w[0][1]),
    .tem_ativo_out(dec_w[0][2]), .atualizar_buffer_out(dec_w[0][3]),
    .expandir_out(expandir_w[0]), .construir_caminho_out(dec_w[0][4]),
    .caminho_pronto_out(dec_w[0][5]), .erro_out(dec_w[0][6]),
    .cod_erro_out(cod_w[0]), .iteracoes_out(iter_w[0]), .estado_out(estado_w[0])
  );

  controlador_busca_multicanal #(
    .N_CANAIS(4), .ITER_W(16), .MAX_ITER(2), .TIMEOUT_W(12), .TIMEOUT(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .iniciar_in(ini), .abortar_in(ab),
    .tem_ativo_in(ta), .aa_pronto_in(ap), .canais_validos_in(cv),
    .lvv_pronto_in(lp), .caminho_pronto_in(cp), .lido_in(li),
    .aguardando_out(dec_w[1][0]), .iniciar_out(dec_w[1][1]),
    .tem_ativo_out(dec_w[1][2]), .atualizar_buffer_out(dec_w[1][3]),
    .expandir_out(expandir_w[1]), .construir_caminho_out(dec_w[1][4]),
    .caminho_pronto_out(dec_w[1][5]), .erro_out(dec_w[1][6]),
    .cod_erro_out(cod_w[1]), .iteracoes_out(iter_w[1]), .estado_out(estado_w[1])
  );

  task automatic chk(input string nome, input int got, input int expv);
    checks++;
    if (got != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, got, expv, $time);
    end
  endtask

  // Expected one-hot state decodes: IDLE,INIT,TEM_ATIVO,ATUALIZAR,CONSTRUIR,PRONTO,ERRO.
  function automatic int dec_of(input int s);
    int r;
    r = 0;
    if (s == 0) r = r | 1;
    if (s == 1) r = r | 2;
    if (s == 2) r = r | 4;
    if (s == 3) r = r | 8;
    if (s == 5) r = r | 16;
    if (s == 6) r = r | 32;
    if (s == 7) r = r | 64;
    return r;
  endfunction

  task automatic model_reset(input int k);
    m_st[k] = 0; m_iter[k] = 0; m_cod[k] = 0; m_pend[k] = 0; m_wd[k] = 0;
  endtask

  // One clock of the sequencer rules, using the inputs present at the edge.
  task automatic model_step(input int k);
    int cur, nxt, p;
    bit expired;
    cur = m_st[k];
    nxt = cur;
    p = m_pend[k];
    expired = (TO[k] != 0) && (cur == 1 || cur == 2 || cur == 4 || cur == 5)
              && (m_wd[k] == TO[k] - 1);
    if (ini) begin
      nxt = 1; m_iter[k] = 0; m_cod[k] = 0; p = 0;
    end else if (ab && !(cur == 0 || cur == 6 || cur == 7)) begin
      nxt = 7; m_cod[k] = 3;
    end else if (expired) begin
      nxt = 7; m_cod[k] = 1;
    end else begin
      case (cur)
        1: if (ta && ap) nxt = 2;
        2: if (ap) begin
             if (!ta) nxt = 5;
             else if (m_iter[k] == MI[k]) begin nxt = 7; m_cod[k] = 2; end
             else begin nxt = 3; m_iter[k] = m_iter[k] + 1; end
           end
        3: begin p = int'(cv); nxt = (p == 0) ? 2 : 4; end
        4: begin p = p & ~int'(lp); if (p == 0) nxt = 2; end
        5: if (cp) nxt = 6;
        6, 7: if (li) nxt = 0;
        default: nxt = cur;
      endcase
    end
    if (nxt != 4) p = 0;
    if (nxt != cur || ini) m_wd[k] = 0;
    else m_wd[k] = m_wd[k] + 1;
    m_st[k] = nxt;
    m_pend[k] = p;
  endtask

  // Advance both models at each edge, then compare both DUTs a little later.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) model_reset(k);
      else model_step(k);
    end
    #2;
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        chk(k == 0 ? "A estado" : "B estado", int'(estado_w[k]), m_st[k]);
        chk(k == 0 ? "A decodes" : "B decodes", int'(dec_w[k]), dec_of(m_st[k]));
        chk(k == 0 ? "A expandir" : "B expandir", int'(expandir_w[k]), m_pend[k]);
        chk(k == 0 ? "A cod_erro" : "B cod_erro", int'(cod_w[k]), m_cod[k]);
        chk(k == 0 ? "A iteracoes" : "B iteracoes", int'(iter_w[k]), m_iter[k]);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) model_reset(k);
    repeat (2) tick();
    chk("reset estado", int'(estado_w[0]), 0);
    chk("reset iteracoes", int'(iter_w[0]), 0);
    chk("reset cod_erro", int'(cod_w[0]), 0);
    chk("reset expandir", int'(expandir_w[0]), 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Round with channels 1011, ch0+ch3 retire together, then ch1.
    ini = 1'b1; tick();
    ini = 1'b0; ta = 1'b1; ap = 1'b1; tick();
    cv = 4'b1011; tick();
    ap = 1'b0; tick();
    chk("r1 expandir first", int'(expandir_w[0]), 11);
    chk("r1 estado", int'(estado_w[0]), 4);
    chk("r1 iteracoes", int'(iter_w[0]), 1);
    lp = 4'b1001; tick();
    chk("r1 expandir after ch0ch3", int'(expandir_w[0]), 2);
    lp = 4'b0010; tick();
    chk("r1 expandir after ch1", int'(expandir_w[0]), 0);
    chk("r1 back to tem_ativo", int'(estado_w[0]), 2);
    lp = 4'b0000;

    // Two empty rounds: A reaches 3 and builds, B hits its limit of 2.
    ap = 1'b1; ta = 1'b1; cv = 4'b0000; tick();
    chk("empty buffer estado", int'(estado_w[0]), 3);
    tick();
    chk("empty buffer no expand", int'(expandir_w[0]), 0);
    chk("empty buffer to tem_ativo", int'(estado_w[0]), 2);
    tick(); tick();
    ta = 1'b0; tick();
    chk("A construir", int'(estado_w[0]), 5);
    chk("A iteracoes 3", int'(iter_w[0]), 3);
    chk("B iter limit erro", int'(estado_w[1]), 7);
    chk("B cod_erro iter", int'(cod_w[1]), 2);
    chk("B iteracoes 2", int'(iter_w[1]), 2);
    ap = 1'b0; cp = 1'b1; tick();
    chk("A pronto", int'(estado_w[0]), 6);
    chk("A caminho_pronto_out", int'(dec_w[0][5]), 1);
    cp = 1'b0; li = 1'b1; tick();
    chk("A idle after lido", int'(estado_w[0]), 0);
    chk("A iteracoes held", int'(iter_w[0]), 3);
    chk("B idle after lido", int'(estado_w[1]), 0);
    chk("B cod_erro kept", int'(cod_w[1]), 2);
    li = 1'b0;

    // Watchdog: no done pulses while expanding.
    ini = 1'b1; tick();
    ini = 1'b0; ta = 1'b1; ap = 1'b1; tick();
    cv = 4'b1111; tick();
    ap = 1'b0; tick();
    repeat (15) tick();
    chk("A still expanding at cycle 16", int'(estado_w[0]), 4);
    tick();
    chk("A timeout erro", int'(estado_w[0]), 7);
    chk("A cod_erro timeout", int'(cod_w[0]), 1);
    chk("A expandir cleared", int'(expandir_w[0]), 0);
    chk("B no watchdog", int'(estado_w[1]), 4);
    chk("B expandir held", int'(expandir_w[1]), 15);
    li = 1'b1; tick();
    li = 1'b0;

    // Abort while building, then start beats abort.
    ini = 1'b1; tick();
    ini = 1'b0; ta = 1'b1; ap = 1'b1; tick();
    ta = 1'b0; tick();
    ap = 1'b0; ab = 1'b1; tick();
    chk("abort erro", int'(estado_w[0]), 7);
    chk("abort cod_erro", int'(cod_w[0]), 3);
    ini = 1'b1; tick();
    chk("start over abort", int'(estado_w[0]), 1);
    chk("start clears cod_erro", int'(cod_w[0]), 0);
    ini = 1'b0; ab = 1'b0;

    // Asynchronous reset in the middle of an expansion.
    ta = 1'b1; ap = 1'b1; tick();
    cv = 4'b0110; tick();
    ap = 1'b0; tick();
    rst_n = 1'b0;
    #1;
    chk("async reset estado", int'(estado_w[0]), 0);
    chk("async reset expandir", int'(expandir_w[0]), 0);
    chk("async reset iteracoes", int'(iter_w[0]), 0);
    tick();
    rst_n = 1'b1;

    // Random traffic against the models.
    repeat (3000) begin
      ini = ($urandom_range(0, 63) == 0);
      ab  = ($urandom_range(0, 79) == 0);
      ta  = ($urandom_range(0, 3) != 0);
      ap  = 1'($urandom_range(0, 1));
      cv  = 4'($urandom_range(0, 15));
      lp  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      cp  = ($urandom_range(0, 3) == 0);
      li  = ($urandom_range(0, 3) == 0);
      tick();
    end
    tick();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
